alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 4-bit combinational ALU.
- Generalised to WIDTH bits and extended with shifts, unsigned compare, and flags.
- Adds iterative multi-cycle multiply, divide and remainder.
- Sits between operand issue logic and writeback; valid/ready on both sides; one operation in flight.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept an operation.
- in_x  in  WIDTH  operand X.
- in_y  in  WIDTH  operand Y.
- in_s  in  4  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_s  out  WIDTH  result.
- out_zero  out  1  out_s == 0.
- out_carry  out  1  carry flag (ADD/SUB only).
- out_ovf  out  1  signed overflow (ADD/SUB only).

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_s=0, all flags 0, iteration counter=0.
- Handshake:
  - Accept on the rising edge where in_valid && in_ready; in_x/in_y/in_s are captured at that edge.
  - Result transfers on the edge where out_valid && out_ready.
  - out_s and flags stay stable while out_valid && !out_ready.
- State machine IDLE/BUSY/DONE:
  - in_ready = (state==IDLE). No back-to-back acceptance, so at most one op per 2 cycles.
  - IDLE -> DONE on accepting a single-cycle op; result is registered and out_valid=1 in the next cycle (latency 1).
  - IDLE -> BUSY on accepting MUL/DIVU/REMU; counter loaded with WIDTH.
  - BUSY: one iteration per cycle for exactly WIDTH cycles, then -> DONE. out_valid rises WIDTH+1 cycles after acceptance.
  - DONE -> IDLE on out_ready. in_ready rises the cycle after the transfer.
- Opcodes (in_s):
  - 0 ADD: x+y.
  - 1 SUB: x+~y+1.
  - 2 NOT: ~x.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SLT: signed x<y; result zero-extended in bit 0.
  - 7 EQ: x==y; result in bit 0.
  - 8 SLTU: unsigned x<y; result in bit 0.
  - 9 SLL: x<<y[SHW-1:0].
  - 10 SRL: logical right shift by y[SHW-1:0].
  - 11 SRA: arithmetic right shift by y[SHW-1:0].
  - 12 MUL: low WIDTH bits of x*y, shift-add iteration.
  - 13 DIVU: unsigned x/y, restoring division.
  - 14 REMU: unsigned x%y, restoring division.
  - 15: result 0, single-cycle.
- Flags:
  - ADD: carry = carry-out.
  - SUB: carry = carry-out of x+~y+1, i.e. 1 when x>=y unsigned.
  - ADD/SUB: ovf = operands' signs (with y inverted for SUB) agree and the result sign differs.
  - All other ops: carry=ovf=0.
  - out_zero reflects out_s for every op.
- Arithmetic: all results are truncated to WIDTH bits. Shift amounts use only the low SHW bits of y; the upper bits of y are ignored.
- Divide by zero (y==0): DIVU returns all ones; REMU returns x. Still takes WIDTH iterations; no exception.
- Ignored inputs: in_valid during BUSY/DONE is ignored; in_x/in_y changes after acceptance have no effect.
- Reset mid-operation: an op in progress is discarded; no out_valid pulse follows.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> out_valid=0, in_ready=1, out_s=0 immediately. Release rst and idle 3 cycles -> no change.
- WIDTH=8 ADD: 0x7F+0x01 -> out_s=0x80, ovf=1, carry=0, zero=0, out_valid 1 cycle after accept. 0xFF+0x01 -> out_s=0x00, carry=1, zero=1.
- WIDTH=8 SUB/compare:
  - SUB 0x03-0x05 -> 0xFE, carry=0.
  - SLT 0xFB,0x02 -> 0x01.
  - SLTU 0xFB,0x02 -> 0x00.
  - EQ 0x5A,0x5A -> 0x01.
  - SRA 0x80 by 0x0B (low 3 bits = 3) -> 0xF0.
- WIDTH=8 MUL 13*11 -> out_s=0x8F, out_valid exactly 9 cycles after accept; in_ready=0 throughout. 0xFF*0xFF -> 0x01.
- WIDTH=8 DIVU/REMU:
  - 100/7 -> 14 (0x0E); 100%7 -> 2.
  - DIVU 0x37/0 -> 0xFF; REMU 0x37/0 -> 0x37.
- Backpressure and abort:
  - Hold out_ready=0 for 3 cycles after out_valid -> out_s/flags stable and in_valid ignored; release -> one transfer, then in_ready=1 next cycle.
  - Assert rst at BUSY iteration 4 of a MUL -> IDLE, no result emitted.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide/remainder, one operation in flight.
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_x_i,
  input  logic [WIDTH-1:0] in_y_i,
  input  logic [3:0]       in_s_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_s_o,
  output logic             out_zero_o,
  output logic             out_carry_o,
  output logic             out_ovf_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [3:0] OP_REMU = 4'd14;

  localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  logic [1:0]       state_q, state_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  // r: product accumulator / partial remainder; a: multiplicand / quotient
  // shifter; b: multiplier shifter / divisor
  logic [WIDTH-1:0] r_q, r_d, a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;

  logic             is_sub, is_iter;
  logic [WIDTH-1:0] y_op, alu_res;
  logic [WIDTH:0]   sum;
  logic             alu_carry, alu_ovf;
  logic [SHW-1:0]   shamt;

  always_comb begin
    is_sub    = (in_s_i == OP_SUB);
    is_iter   = (in_s_i == OP_MUL) || (in_s_i == OP_DIVU) || (in_s_i == OP_REMU);
    y_op      = is_sub ? ~in_y_i : in_y_i;
    sum       = {1'b0, in_x_i} + {1'b0, y_op} + {{WIDTH{1'b0}}, is_sub};
    shamt     = in_y_i[SHW-1:0];
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (in_s_i)
      OP_ADD, OP_SUB: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (in_x_i[WIDTH-1] == y_op[WIDTH-1]) &&
                    (sum[WIDTH-1] != in_x_i[WIDTH-1]);
      end
      OP_NOT:  alu_res = ~in_x_i;
      OP_AND:  alu_res = in_x_i & in_y_i;
      OP_OR:   alu_res = in_x_i | in_y_i;
      OP_XOR:  alu_res = in_x_i ^ in_y_i;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_x_i) < $signed(in_y_i))};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (in_x_i == in_y_i)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_x_i < in_y_i)};
      OP_SLL:  alu_res = in_x_i << shamt;
      OP_SRL:  alu_res = in_x_i >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(in_x_i) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  logic [WIDTH-1:0] r_it, a_it, b_it, iter_res;
  logic [WIDTH:0]   shifted, trial;

  // One iteration of the multi-cycle op held in op_q. With a zero divisor the
  // trial subtraction never borrows, giving all-ones quotient and remainder x.
  always_comb begin
    shifted = {r_q, a_q[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
    if (op_q == OP_MUL) begin
      r_it = r_q + (b_q[0] ? a_q : '0);
      a_it = a_q << 1;
      b_it = b_q >> 1;
    end else begin
      r_it = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      a_it = {a_q[WIDTH-2:0], ~trial[WIDTH]};
      b_it = b_q;
    end
    iter_res = (op_q == OP_DIVU) ? a_it : r_it;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    r_d     = r_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          op_d = in_s_i;
          if (is_iter) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
            r_d     = '0;
            a_d     = in_x_i;
            b_d     = in_y_i;
          end else begin
            state_d = DONE;
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
            carry_d = alu_carry;
            ovf_d   = alu_ovf;
          end
        end
      end
      BUSY: begin
        r_d   = r_it;
        a_d   = a_it;
        b_d   = b_it;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
          res_d   = iter_res;
          zero_d  = (iter_res == '0);
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      r_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      r_q     <= r_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign out_s_o     = res_q;
  assign out_zero_o  = zero_q;
  assign out_carry_o = carry_q;
  assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq (WIDTH=8) against an arithmetic
// reference model; each scenario task does its own comparisons.
module tb_alu_seq;

  localparam int W = 8;
  localparam int TIMEOUT = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [W-1:0] inX = '0;
  logic [W-1:0] inY = '0;
  logic [3:0]   inS = '0;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [W-1:0] outS;
  logic         outZero, outCarry, outOvf;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(inValid), .in_ready_o(inReady),
    .in_x_i(inX), .in_y_i(inY), .in_s_i(inS),
    .out_valid_o(outValid), .out_ready_i(outReady),
    .out_s_o(outS), .out_zero_o(outZero),
    .out_carry_o(outCarry), .out_ovf_o(outOvf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic c, output logic o);
    longint ux, uy, sx, sy, m, v, smax, smin;
    int sh;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    m = longint'(1) << W;
    smax = (m / 2) - 1;
    smin = -(m / 2);
    sh = int'(uy % W);
    c = 1'b0;
    o = 1'b0;
    case (s)
      4'd0: begin v = ux + uy; c = (v >= m); o = (sx + sy > smax) || (sx + sy < smin); end
      4'd1: begin v = ux - uy + m; c = (ux >= uy); o = (sx - sy > smax) || (sx - sy < smin); end
      4'd2: v = (m - 1) - ux;
      4'd3: v = longint'(x & y);
      4'd4: v = longint'(x | y);
      4'd5: v = longint'(x ^ y);
      4'd6: v = (sx < sy) ? 1 : 0;
      4'd7: v = (ux == uy) ? 1 : 0;
      4'd8: v = (ux < uy) ? 1 : 0;
      4'd9: v = ux * (longint'(1) << sh);
      4'd10: v = ux / (longint'(1) << sh);
      4'd11: v = sx >>> sh;
      4'd12: v = ux * uy;
      4'd13: v = (uy == 0) ? m - 1 : ux / uy;
      4'd14: v = (uy == 0) ? ux : ux % uy;
      default: v = 0;
    endcase
    v = ((v % m) + m) % m;
    r = v[W-1:0];
  endfunction

  function automatic int modelLatency(input logic [3:0] s);
    return (s >= 4'd12 && s <= 4'd14) ? W + 1 : 1;
  endfunction

  // Drives one transaction from IDLE and collects the result; no checking.
  task automatic runOp(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output logic [W-1:0] r, output logic z,
                       output logic c, output logic o, output logic readyLow);
    @(negedge clk);
    inValid = 1'b1;
    inS = s;
    inX = x;
    inY = y;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inX = W'($urandom);
    inY = W'($urandom);
    inS = 4'($urandom);
    lat = 0;
    readyLow = 1'b1;
    while (lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
      if (inReady) readyLow = 1'b0;
      if (outValid) break;
    end
    r = outS;
    z = outZero;
    c = outCarry;
    o = outOvf;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    inValid = 1'b1; inS = 4'd0; inX = 8'h12; inY = 8'h34;
    @(posedge clk);
    #1 inValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1 || outS !== '0 ||
        outZero !== 1'b0 || outCarry !== 1'b0 || outOvf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: valid=%b ready=%b s=%h z=%b c=%b o=%b, required 0 1 00 0 0 0",
               outValid, inReady, outS, outZero, outCarry, outOvf);
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1 || outS !== '0) begin
      errors++;
      $display("[TB] FAIL reset_idle: valid=%b ready=%b s=%h, required 0 1 00", outValid, inReady, outS);
    end
  endtask

  typedef struct {
    logic [3:0]   s;
    logic [W-1:0] x, y, r;
    logic         z, c, o;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[$];
    int lat;
    logic [W-1:0] r;
    logic z, c, o, rl;
    vecs.push_back('{4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{4'd1,  8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd6,  8'hFB, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd8,  8'hFB, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{4'd7,  8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd11, 8'h80, 8'h0B, 8'hF0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd12, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd12, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd13, 8'd100, 8'd7, 8'd14, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd14, 8'd100, 8'd7, 8'd2, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd13, 8'h37, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd14, 8'h37, 8'h00, 8'h37, 1'b0, 1'b0, 1'b0});
    foreach (vecs[i]) begin
      runOp(vecs[i].s, vecs[i].x, vecs[i].y, lat, r, z, c, o, rl);
      checks++;
      if (r !== vecs[i].r || z !== vecs[i].z || c !== vecs[i].c || o !== vecs[i].o) begin
        errors++;
        $display("[TB] FAIL directed_%0d op=%0d: got s=%h z=%b c=%b o=%b, required s=%h z=%b c=%b o=%b",
                 i, vecs[i].s, r, z, c, o, vecs[i].r, vecs[i].z, vecs[i].c, vecs[i].o);
      end
      checks++;
      if (lat !== modelLatency(vecs[i].s) || rl !== 1'b1) begin
        errors++;
        $display("[TB] FAIL directed_latency_%0d op=%0d: got %0d cycles readyLow=%b, required %0d cycles readyLow=1",
                 i, vecs[i].s, lat, rl, modelLatency(vecs[i].s));
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] x, y, r, er;
    logic [3:0] s;
    logic z, c, o, rl, ec, eo;
    for (int i = 0; i < 150; i++) begin
      s = 4'($urandom);
      x = W'($urandom);
      y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      model(s, x, y, er, ec, eo);
      runOp(s, x, y, lat, r, z, c, o, rl);
      checks++;
      if (r !== er || z !== (er == '0) || c !== ec || o !== eo || lat !== modelLatency(s)) begin
        errors++;
        $display("[TB] FAIL random_%0d op=%0d x=%h y=%h: got s=%h z=%b c=%b o=%b lat=%0d, required s=%h z=%b c=%b o=%b lat=%0d",
                 i, s, x, y, r, z, c, o, lat, er, (er == '0), ec, eo, modelLatency(s));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] x, y, er;
    logic ec, eo;
    x = W'($urandom);
    y = W'($urandom);
    model(4'd0, x, y, er, ec, eo);
    @(negedge clk);
    inValid = 1'b1; inS = 4'd0; inX = x; inY = y;
    @(posedge clk);
    #1 inValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      inValid = 1'b1;
      inS = 4'd2;
      inX = W'($urandom);
      inY = W'($urandom);
      @(negedge clk);
      checks++;
      if (outValid !== 1'b1 || inReady !== 1'b0 || outS !== er ||
          outZero !== (er == '0) || outCarry !== ec || outOvf !== eo) begin
        errors++;
        $display("[TB] FAIL backpressure_hold_%0d: valid=%b ready=%b s=%h c=%b o=%b, required 1 0 %h %b %b",
                 k, outValid, inReady, outS, outCarry, outOvf, er, ec, eo);
      end
    end
    inValid = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1 outReady = 1'b0;
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL backpressure_release: valid=%b ready=%b, required 0 1", outValid, inReady);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL backpressure_no_ghost: valid=%b ready=%b, required 0 1", outValid, inReady);
    end
  endtask

  task automatic test_abort();
    logic sawValid;
    int lat;
    logic [W-1:0] r;
    logic z, c, o, rl;
    @(negedge clk);
    inValid = 1'b1; inS = 4'd12; inX = 8'd13; inY = 8'd11;
    @(posedge clk);
    #1 inValid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_reset: ready=%b valid=%b, required 1 0", inReady, outValid);
    end
    @(negedge clk) rst = 1'b0;
    sawValid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (outValid) sawValid = 1'b1;
    end
    checks++;
    if (sawValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_result: saw out_valid=%b, required 0", sawValid);
    end
    runOp(4'd5, 8'hA5, 8'h0F, lat, r, z, c, o, rl);
    checks++;
    if (r !== 8'hAA || lat !== 1) begin
      errors++;
      $display("[TB] FAIL abort_recover: got s=%h lat=%0d, required s=aa lat=1", r, lat);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
